// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned MULTU/DIVU engine that borrows the shared 32-bit ALU,
// issuing one add (multiply) or subtract (restoring divide) per cycle.
module alu_muldiv_seq #(
  parameter logic [3:0] ALU_AND = 4'd0,
  parameter logic [3:0] ALU_ADD = 4'd2,
  parameter logic [3:0] ALU_SUB = 4'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_signal,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} stateT;

  stateT       stateQ, stateD;
  logic [4:0]  cntQ, cntD;
  logic [31:0] hiQ, hiD;      // P (multiply) or R (divide)
  logic [31:0] loQ, loD;      // Q: multiplier / dividend-quotient
  logic [31:0] mQ, mD;        // M (multiplicand) or D (divisor)
  logic        divZeroQ, divZeroD;
  logic        carry, borrow;
  logic [31:0] shifted;

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    hiD        = hiQ;
    loD        = loQ;
    mD         = mQ;
    divZeroD   = divZeroQ;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    alu_signal = ALU_AND;
    carry      = 1'b0;
    borrow     = 1'b0;
    shifted    = 32'd0;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          cntD = 5'd0;
          if (!op) begin
            hiD      = 32'd0;
            loD      = src_b;
            mD       = src_a;
            divZeroD = 1'b0;
            stateD   = StMul;
          end else if (src_b != 32'd0) begin
            hiD      = 32'd0;
            loD      = src_a;
            mD       = src_b;
            divZeroD = 1'b0;
            stateD   = StDiv;
          end else begin
            hiD      = src_a;
            loD      = 32'hFFFF_FFFF;
            mD       = src_b;
            divZeroD = 1'b1;
            stateD   = StDone;
          end
        end
      end

      StMul: begin
        alu_a      = hiQ;
        alu_b      = mQ;
        alu_signal = ALU_ADD;
        carry      = (hiQ[31] & mQ[31]) | ((hiQ[31] | mQ[31]) & ~alu_result[31]);
        if (loQ[0]) begin
          hiD = {carry, alu_result[31:1]};
          loD = {alu_result[0], loQ[31:1]};
        end else begin
          hiD = {1'b0, hiQ[31:1]};
          loD = {hiQ[0], loQ[31:1]};
        end
        cntD = cntQ + 5'd1;
        if (cntQ == 5'd31) stateD = StDone;
      end

      StDiv: begin
        shifted    = {hiQ[30:0], loQ[31]};
        alu_a      = shifted;
        alu_b      = mQ;
        alu_signal = ALU_SUB;
        borrow     = (~shifted[31] & mQ[31]) | (~(shifted[31] ^ mQ[31]) & alu_result[31]);
        // A set R[31] means the shifted-out bit makes S >= D regardless of borrow.
        if (hiQ[31] | ~borrow) begin
          hiD = alu_result;
          loD = {loQ[30:0], 1'b1};
        end else begin
          hiD = shifted;
          loD = {loQ[30:0], 1'b0};
        end
        cntD = cntQ + 5'd1;
        if (cntQ == 5'd31) stateD = StDone;
      end

      StDone: stateD = StIdle;

      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= StIdle;
      cntQ     <= 5'd0;
      hiQ      <= 32'd0;
      loQ      <= 32'd0;
      mQ       <= 32'd0;
      divZeroQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      hiQ      <= hiD;
      loQ      <= loD;
      mQ       <= mD;
      divZeroQ <= divZeroD;
    end
  end

  assign busy     = (stateQ != StIdle);
  assign done     = (stateQ == StDone);
  assign hi       = hiQ;
  assign lo       = loQ;
  assign div_zero = divZeroQ;

endmodule
